// File: rtl/seg7_scan_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_decoder_if
// Brief    : Scanned 7-segment bus plus the decoded-frame results.
// Revision : 1.0
// ============================================================================
interface seg7_scan_decoder_if;
    logic [3:0]  disp_anode;
    logic [7:0]  disp_seg;
    logic        frame_valid;
    logic [15:0] frame_value;
    logic [3:0]  frame_dp;
    logic [3:0]  frame_err;
    logic        scan_stalled;

    modport master (
        output disp_anode, disp_seg,
        input  frame_valid, frame_value, frame_dp, frame_err, scan_stalled
    );

    modport slave (
        input  disp_anode, disp_seg,
        output frame_valid, frame_value, frame_dp, frame_err, scan_stalled
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_decoder
// Brief    : Samples a multiplexed 7-segment scan, rejects ghosting and
//            rebuilds the four displayed hex digits as a 16-bit frame.
// Revision : 1.0
// ============================================================================
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16
) (
    input  logic               clock,
    input  logic               reset_in,
    seg7_scan_decoder_if.slave bus
);
    localparam int               SC_W          = $clog2(STABLE_CYCLES + 1);
    localparam logic [SC_W-1:0]  c_stable_max  = SC_W'(STABLE_CYCLES);
    localparam logic [SC_W-1:0]  c_stable_last = SC_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout     = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [11:0]      c_sync_idle   = 12'hFFF;

    logic [11:0]      r_s1;
    logic [11:0]      r_s2;
    logic [11:0]      r_s3;
    logic [SC_W-1:0]  r_stable_cnt;
    logic             r_done;
    logic [3:0]       r_mask;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_frame_valid;
    logic [15:0]      r_frame_value;
    logic [3:0]       r_frame_dp;
    logic [3:0]       r_frame_err;

    logic [3:0]  w_sel;
    logic [7:0]  w_seg;
    logic        w_same;
    logic        w_capture;
    logic [3:0]  w_mask_next;
    logic        w_frame_done;
    logic [3:0]  w_dec_nib;
    logic        w_dec_err;
    logic        w_dec_dp;
    logic [15:0] w_asm_value;
    logic [3:0]  w_asm_dp;
    logic [3:0]  w_asm_err;

    assign w_sel        = ~r_s2[11:8];
    assign w_seg        = r_s2[7:0];
    assign w_same       = (r_s2 == r_s3);
    assign w_capture    = w_same && (r_stable_cnt == c_stable_last) &&
                          $onehot(w_sel) && !r_done;
    assign w_mask_next  = r_mask | w_sel;
    assign w_frame_done = w_capture && (w_mask_next == 4'hF);
    assign w_dec_dp     = ~w_seg[7];

    always_comb begin
        w_dec_nib = 4'h0;
        w_dec_err = 1'b0;
        case (w_seg[6:0])
            7'h40:   w_dec_nib = 4'h0;
            7'h79:   w_dec_nib = 4'h1;
            7'h24:   w_dec_nib = 4'h2;
            7'h30:   w_dec_nib = 4'h3;
            7'h19:   w_dec_nib = 4'h4;
            7'h12:   w_dec_nib = 4'h5;
            7'h02:   w_dec_nib = 4'h6;
            7'h78:   w_dec_nib = 4'h7;
            7'h00:   w_dec_nib = 4'h8;
            7'h10:   w_dec_nib = 4'h9;
            7'h08:   w_dec_nib = 4'hA;
            7'h03:   w_dec_nib = 4'hB;
            7'h46:   w_dec_nib = 4'hC;
            7'h21:   w_dec_nib = 4'hD;
            7'h06:   w_dec_nib = 4'hE;
            7'h0E:   w_dec_nib = 4'hF;
            default: w_dec_err = 1'b1;
        endcase
    end

    // Working digit store; the frame view substitutes the digit being captured
    // so the completing capture lands in the same frame.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        logic [3:0] r_nib;
        logic       r_dp;
        logic       r_err;

        always_ff @(posedge clock or negedge reset_in) begin
            if (!reset_in) begin
                r_nib <= 4'h0;
                r_dp  <= 1'b0;
                r_err <= 1'b0;
            end else if (w_capture && w_sel[gi]) begin
                r_nib <= w_dec_nib;
                r_dp  <= w_dec_dp;
                r_err <= w_dec_err;
            end
        end

        assign w_asm_value[gi*4 +: 4] = w_sel[gi] ? w_dec_nib : r_nib;
        assign w_asm_dp[gi]           = w_sel[gi] ? w_dec_dp  : r_dp;
        assign w_asm_err[gi]          = w_sel[gi] ? w_dec_err : r_err;
    end

    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            r_s1          <= c_sync_idle;
            r_s2          <= c_sync_idle;
            r_s3          <= c_sync_idle;
            r_stable_cnt  <= '0;
            r_done        <= 1'b0;
            r_mask        <= 4'h0;
            r_stall_cnt   <= '0;
            r_frame_valid <= 1'b0;
            r_frame_value <= 16'h0000;
            r_frame_dp    <= 4'h0;
            r_frame_err   <= 4'h0;
        end else begin
            r_s1 <= {bus.disp_anode, bus.disp_seg};
            r_s2 <= r_s1;
            r_s3 <= r_s2;

            // Capture-done only re-arms once the sampled bus changes.
            if (!w_same) begin
                r_stable_cnt <= '0;
                r_done       <= 1'b0;
            end else begin
                if (r_stable_cnt != c_stable_max) begin
                    r_stable_cnt <= r_stable_cnt + 1'b1;
                end
                if (w_capture) begin
                    r_done <= 1'b1;
                end
            end

            if (w_capture) begin
                r_stall_cnt <= '0;
                r_mask      <= w_frame_done ? 4'h0 : w_mask_next;
            end else if (r_stall_cnt != c_timeout) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            r_frame_valid <= w_frame_done;
            if (w_frame_done) begin
                r_frame_value <= w_asm_value;
                r_frame_dp    <= w_asm_dp;
                r_frame_err   <= w_asm_err;
            end
        end
    end

    assign bus.frame_valid  = r_frame_valid;
    assign bus.frame_value  = r_frame_value;
    assign bus.frame_dp     = r_frame_dp;
    assign bus.frame_err    = r_frame_err;
    assign bus.scan_stalled = (r_stall_cnt == c_timeout);
endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_decoder
// Brief    : Directed plus randomized scan stimulus for seg7_scan_decoder.
// Revision : 1.0
// ============================================================================
module tb_seg7_scan_decoder;
    localparam int STABLE_CYCLES  = 4;
    localparam int TIMEOUT_CYCLES = 20;
    localparam int CNT_W          = 16;

    logic clock    = 1'b0;
    logic reset_in = 1'b0;
    always #5 clock = ~clock;

    seg7_scan_decoder_if bus ();

    seg7_scan_decoder #(
        .STABLE_CYCLES  (STABLE_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clock    (clock),
        .reset_in (reset_in),
        .bus      (bus)
    );

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int   passed     = 0;
    int   total      = 0;
    int   cyc        = 0;
    int   fv_hi      = 0;
    int   last_fv    = -1;
    int   stall_rise = -1;
    logic prev_st    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (bus.frame_valid === 1'b1) begin
            fv_hi++;
            last_fv = cyc;
        end
        if (bus.scan_stalled === 1'b1 && !prev_st) stall_rise = cyc;
        prev_st = (bus.scan_stalled === 1'b1);
    endtask

    task automatic drive(input logic [3:0] an, input logic [7:0] sg, input int n);
        bus.disp_anode = an;
        bus.disp_seg   = sg;
        repeat (n) tick();
    endtask

    function automatic logic [7:0] glyph(input int v, input logic dp);
        return {~dp, seg_tab[v]};
    endfunction

    function automatic int find_pat(input logic [6:0] p);
        for (int k = 0; k < 16; k++) if (seg_tab[k] == p) return k;
        return -1;
    endfunction

    task automatic scan4(input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3);
        drive(4'hE, s0, 10);
        drive(4'hD, s1, 10);
        drive(4'hB, s2, 10);
        drive(4'h7, s3, 10);
        drive(4'hF, 8'hFF, 4);
    endtask

    task automatic check_frame(input string tag, input logic [15:0] v, input logic [3:0] dp,
                               input logic [3:0] err, input int pulses);
        check({tag, "_value"}, bus.frame_value, v);
        check({tag, "_dp"}, bus.frame_dp, dp);
        check({tag, "_err"}, bus.frame_err, err);
        check({tag, "_pulses"}, fv_hi, pulses);
    endtask

    initial begin
        int         kind;
        int         len;
        int         d;
        int         idx;
        int         exp_pulses;
        logic [3:0] an;
        logic [7:0] sg;
        logic [6:0] pat;
        logic       dp_b;
        logic [11:0] prev;
        logic [3:0] m_nib [4];
        logic [3:0] m_dp;
        logic [3:0] m_err;
        logic [3:0] m_mask;
        logic [15:0] exp_value;
        logic [3:0] exp_dp;
        logic [3:0] exp_err;

        bus.disp_anode = 4'hF;
        bus.disp_seg   = 8'hFF;
        #12;
        check("reset_valid", bus.frame_valid, 0);
        check("reset_value", bus.frame_value, 0);
        check("reset_dp", bus.frame_dp, 0);
        check("reset_err", bus.frame_err, 0);
        check("reset_stalled", bus.scan_stalled, 0);
        reset_in = 1'b1;
        drive(4'hF, 8'hFF, 3);

        fv_hi = 0;
        scan4(glyph(15, 0), glyph(10, 0), glyph(2, 0), glyph(1, 0));
        check_frame("scan_12af", 16'h12AF, 4'h0, 4'h0, 1);

        // Short "8" ghost on digit 0 between real dwells must be ignored.
        fv_hi = 0;
        drive(4'hE, glyph(15, 0), 10);
        drive(4'hE, 8'h00, 2);
        drive(4'hD, glyph(10, 0), 10);
        drive(4'hB, glyph(2, 0), 10);
        drive(4'h7, glyph(1, 0), 10);
        drive(4'hF, 8'hFF, 4);
        check_frame("ghost", 16'h12AF, 4'h0, 4'h0, 1);

        fv_hi = 0;
        scan4(glyph(5, 0), glyph(4, 0), 8'h7F, glyph(3, 0));
        check_frame("dp_invalid", 16'h3045, 4'b0100, 4'b0100, 1);

        fv_hi = 0;
        drive(4'hE, glyph(5, 0), 100);
        check("long_dwell_no_frame", fv_hi, 0);
        drive(4'hE, glyph(6, 0), 10);
        drive(4'hD, glyph(7, 0), 10);
        drive(4'hB, glyph(8, 0), 10);
        stall_rise = -1;
        drive(4'h7, glyph(9, 0), 10);
        drive(4'hF, 8'hFF, 30);
        check_frame("recapture", 16'h9876, 4'h0, 4'h0, 1);
        check("stall_latency", 32'(stall_rise - last_fv), 32'(TIMEOUT_CYCLES));
        check("stall_high", bus.scan_stalled, 1);
        drive(4'hE, glyph(1, 0), 10);
        check("stall_cleared", bus.scan_stalled, 0);

        drive(4'hF, 8'hFF, 3);
        drive(4'hE, glyph(1, 0), 10);
        drive(4'hD, glyph(2, 0), 10);
        drive(4'hB, glyph(3, 0), 10);
        drive(4'hF, 8'hFF, 2);
        #2;
        reset_in = 1'b0;
        #1;
        check("async_rst_valid", bus.frame_valid, 0);
        check("async_rst_value", bus.frame_value, 0);
        check("async_rst_dp", bus.frame_dp, 0);
        check("async_rst_err", bus.frame_err, 0);
        check("async_rst_stalled", bus.scan_stalled, 0);
        #20;
        reset_in = 1'b1;
        fv_hi = 0;
        drive(4'h7, glyph(0, 0), 10);
        drive(4'hF, 8'hFF, 6);
        check("reset_mask_discarded", fv_hi, 0);
        scan4(glyph(0, 0), glyph(0, 0), glyph(0, 0), glyph(0, 0));
        check_frame("post_reset_0000", 16'h0000, 4'h0, 4'h0, 1);

        // Random runs: dwells of 6+ cycles always count, runs of 1..3 never do.
        for (int k = 0; k < 4; k++) m_nib[k] = 4'h0;
        m_dp       = 4'h0;
        m_err      = 4'h0;
        m_mask     = 4'h0;
        exp_value  = 16'h0000;
        exp_dp     = 4'h0;
        exp_err    = 4'h0;
        exp_pulses = 0;
        fv_hi      = 0;
        prev       = 12'hFFF;
        for (int r = 0; r < 250; r++) begin
            kind = $urandom_range(0, 9);
            do begin
                d = 0;
                if (kind < 6) begin
                    d  = $urandom_range(0, 3);
                    an = 4'hF;
                    an[d] = 1'b0;
                    if ($urandom_range(0, 7) != 0) begin
                        pat = seg_tab[$urandom_range(0, 15)];
                    end else begin
                        do pat = 7'($urandom); while (find_pat(pat) >= 0);
                    end
                    dp_b = 1'($urandom_range(0, 1));
                    sg   = {~dp_b, pat};
                    len  = $urandom_range(6, 12);
                end else if (kind < 8) begin
                    an  = 4'($urandom);
                    sg  = 8'($urandom);
                    len = $urandom_range(1, 3);
                end else begin
                    do an = 4'($urandom); while ($onehot(~an));
                    sg  = 8'($urandom);
                    len = $urandom_range(1, 8);
                end
            end while ({an, sg} == prev);
            drive(an, sg, len);
            prev = {an, sg};
            if (kind < 6) begin
                idx = find_pat(sg[6:0]);
                m_nib[d] = (idx >= 0) ? 4'(idx) : 4'h0;
                m_err[d] = (idx < 0);
                m_dp[d]  = ~sg[7];
                m_mask[d] = 1'b1;
                if (m_mask == 4'hF) begin
                    exp_value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                    exp_dp    = m_dp;
                    exp_err   = m_err;
                    m_mask    = 4'h0;
                    exp_pulses++;
                    drive(4'hF, 8'hFF, 8);
                    prev = 12'hFFF;
                    check_frame("random", exp_value, exp_dp, exp_err, exp_pulses);
                end
            end
        end
        drive(4'hF, 8'hFF, 10);
        check_frame("random_end", exp_value, exp_dp, exp_err, exp_pulses);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
